// File: rtl/seg7_scan_decoder.sv
// Receive-side 7-segment scan decoder: syncs multiplexed seg/anode lines, waits for a stable
// (seg,anode) pair, then decodes it into a per-digit hex value. Optional macro: SEG7_BLANK_DETECT_EN.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    input  logic                      err_clr,
    output logic [4*NUM_DIGITS-1:0]   digits_out,
    output logic [NUM_DIGITS-1:0]     digit_valid,
    output logic                      upd_pulse,
    output logic [IDX_W-1:0]          upd_idx,
    output logic                      err
);

    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);

    logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d, an_prev_q, an_prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    committed_q, committed_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic                    upd_pulse_q, upd_pulse_d;
    logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
    logic                    err_q, err_d;

    logic                    changed;
    logic                    one_low;
    logic                    commit_now;
    logic                    blank;
    logic                    dec_ok;
    logic [3:0]              dec_val;
    logic [NUM_DIGITS-1:0]   sel;

    // Returns {valid, value}; only the exact encoder patterns are accepted.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E: decode = 5'h10;
            7'h30: decode = 5'h11;
            7'h6D: decode = 5'h12;
            7'h79: decode = 5'h13;
            7'h33: decode = 5'h14;
            7'h5B: decode = 5'h15;
            7'h5F: decode = 5'h16;
            7'h70: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h7B: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h1F: decode = 5'h1B;
            7'h4E: decode = 5'h1C;
            7'h3D: decode = 5'h1D;
            7'h4F: decode = 5'h1E;
            7'h47: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        seg_s1_d   = seg_in;
        seg_s2_d   = seg_s1_q;
        seg_prev_d = seg_s2_q;
        an_s1_d    = an_in;
        an_s2_d    = an_s1_q;
        an_prev_d  = an_s2_q;

        changed = (seg_s2_q != seg_prev_q) || (an_s2_q != an_prev_q);
        sel     = ~an_s2_q;
        one_low = (sel != '0) && ((sel & (sel - AN_ONE)) == '0);
        {dec_ok, dec_val} = decode(seg_s2_q);
`ifdef SEG7_BLANK_DETECT_EN
        blank = (seg_s2_q == 7'h00);
`else
        blank = 1'b0;
`endif
        // Pattern must still match the previous sample on the commit cycle itself.
        commit_now = !changed && !committed_q && one_low &&
                     (cnt_q == CNT_W'(STABLE_CYCLES - 1));

        if (changed)
            cnt_d = '0;
        else if (cnt_q != CNT_W'(STABLE_CYCLES))
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;

        committed_d = changed ? 1'b0 : (committed_q || commit_now);

        digits_d    = digits_q;
        valid_d     = valid_q;
        upd_pulse_d = commit_now;
        upd_idx_d   = upd_idx_q;
        err_d       = err_clr ? 1'b0 : err_q;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit_now && sel[i]) begin
                upd_idx_d = IDX_W'(i);
                if (dec_ok) begin
                    digits_d[4*i +: 4] = dec_val;
                    valid_d[i]         = 1'b1;
                end else begin
                    valid_d[i] = 1'b0;
                    if (!blank)
                        err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            seg_prev_q  <= '0;
            an_s1_q     <= '0;
            an_s2_q     <= '0;
            an_prev_q   <= '0;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            digits_q    <= '0;
            valid_q     <= '0;
            upd_pulse_q <= 1'b0;
            upd_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            seg_s1_q    <= seg_s1_d;
            seg_s2_q    <= seg_s2_d;
            seg_prev_q  <= seg_prev_d;
            an_s1_q     <= an_s1_d;
            an_s2_q     <= an_s2_d;
            an_prev_q   <= an_prev_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            upd_pulse_q <= upd_pulse_d;
            upd_idx_q   <= upd_idx_d;
            err_q       <= err_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign upd_pulse   = upd_pulse_q;
    assign upd_idx     = upd_idx_q;
    assign err         = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scan patterns, expected commits queued and checked on each upd_pulse.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        err_clr;
    logic [15:0] digits_out;
    logic [3:0]  digit_valid;
    logic        upd_pulse;
    logic [1:0]  upd_idx;
    logic        err;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .err_clr(err_clr),
        .digits_out(digits_out), .digit_valid(digit_valid), .upd_pulse(upd_pulse),
        .upd_idx(upd_idx), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [15:0] dig;
        logic [3:0]  vld;
        logic        e;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_dig   = '0;
    logic [3:0]  m_vld   = '0;
    logic        m_err   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation, including its edge number.
    always @(negedge clk) begin
        if (rst_n && upd_pulse) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse idx %0d at cycle %0d, expected none",
                         upd_idx, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("upd_idx", int'(upd_idx), e.idx);
                chk("digits_out", int'(digits_out), int'(e.dig));
                chk("digit_valid", int'(digit_valid), int'(e.vld));
                chk("err", int'(err), int'(e.e));
            end
        end
    end

    // Drive a (seg,an) pair for 'hold' edges; if a commit is expected, update the model and queue it.
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold,
                         input bit commit, input logic [3:0] val, input bit vld, input bit clr);
        int   e0;
        int   idx;
        exp_t x;
        @(posedge clk);
        #1;
        an_in  = an;
        seg_in = seg;
        e0     = cyc;
        if (commit) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
            if (vld) begin
                m_dig[4*idx +: 4] = val;
                m_vld[idx]        = 1'b1;
            end else begin
                m_vld[idx] = 1'b0;
`ifdef SEG7_BLANK_DETECT_EN
                if (seg != 7'h00) m_err = 1'b1;
`else
                m_err = 1'b1;
`endif
            end
            x.idx = idx; x.dig = m_dig; x.vld = m_vld; x.e = m_err; x.at = e0 + 11;
            sb.push_back(x);
        end
        if (clr) begin
            repeat (10) @(posedge clk);
            #1 err_clr = 1'b1;
            @(posedge clk);
            #1 err_clr = 1'b0;
            repeat (hold - 12) @(posedge clk);
        end else begin
            repeat (hold - 1) @(posedge clk);
        end
    endtask

    initial begin
        int e1;
        exp_t x;
        rst_n   = 1'b0;
        an_in   = 4'hF;
        seg_in  = 7'h00;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_digits", int'(digits_out), 0);
        chk("rst_valid", int'(digit_valid), 0);
        chk("rst_pulse", int'(upd_pulse), 0);
        chk("rst_idx", int'(upd_idx), 0);
        chk("rst_err", int'(err), 0);

        // Idle, blanked: nothing may commit.
        repeat (20) @(posedge clk);
        #1;
        chk("idle_digits", int'(digits_out), 0);
        chk("idle_valid", int'(digit_valid), 0);

        // Single digit 0 showing 5.
        drive(4'b1110, 7'h5B, 20, 1, 4'h5, 1, 0);
        #1;
        chk("d0_slice", int'(digits_out[3:0]), 5);
        chk("d0_valid", int'(digit_valid), 4'b0001);

        // Two scan passes 0,1,2,3.
        for (int p = 0; p < 2; p++) begin
            drive(4'b1110, 7'h7E, 16, 1, 4'h0, 1, 0);
            drive(4'b1101, 7'h30, 16, 1, 4'h1, 1, 0);
            drive(4'b1011, 7'h6D, 16, 1, 4'h2, 1, 0);
            drive(4'b0111, 7'h79, 16, 1, 4'h3, 1, 0);
        end
        #1;
        chk("scan_digits", int'(digits_out), 16'h3210);
        chk("scan_valid", int'(digit_valid), 4'hF);

        // Glitching digit 2 never settles long enough to commit.
        for (int g = 0; g < 10; g++)
            drive(4'b1011, (g % 2) ? 7'h6D : 7'h7F, 3, 0, 4'h0, 0, 0);
        drive(4'b1111, 7'h7F, 20, 0, 4'h0, 0, 0);
        #1;
        chk("glitch_slice2", int'(digits_out[11:8]), 2);
        chk("glitch_valid2", int'(digit_valid[2]), 1);

        // All-off pattern on digit 1.
        drive(4'b1101, 7'h00, 16, 1, 4'h0, 0, 0);
        #1;
        chk("blank_valid", int'(digit_valid), 4'b1101);
        chk("blank_slice1", int'(digits_out[7:4]), 1);
        chk("blank_err", int'(err), int'(m_err));
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        m_err = 1'b0;
        chk("err_cleared", int'(err), 0);

        // Invalid commit on digit 3 with err_clr in the same cycle: set wins.
        drive(4'b0111, 7'h01, 16, 1, 4'h0, 0, 1);
        #1;
        chk("err_set_wins", int'(err), 1);
        chk("inv_slice3", int'(digits_out[15:12]), 3);
        chk("inv_valid", int'(digit_valid), 4'b0101);

        // Reset while digit 0 is settling (cnt=5).
        @(posedge clk);
        #1;
        an_in  = 4'b1110;
        seg_in = 7'h30;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", int'(digits_out), 0);
        chk("mid_rst_valid", int'(digit_valid), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_idx", int'(upd_idx), 0);
        m_dig = '0; m_vld = '0; m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        e1 = cyc;
        m_dig[3:0] = 4'h1;
        m_vld[0]   = 1'b1;
        x.idx = 0; x.dig = m_dig; x.vld = m_vld; x.e = 1'b0; x.at = e1 + 11;
        sb.push_back(x);
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_digits", int'(digits_out), 16'h0001);
        chk("pending_expected", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
